// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32 memory-access stage: byte/half/word load/store over a req/ack data-RAM port
// Optional feature macro: MEM_MISALIGN_TRAP_EN (trap misaligned half/word accesses instead of truncating)
module mem_stage (
   input  logic        clk,
   input  logic        arst_n,
   input  logic [31:0] inst_i,
   input  logic        reg_w_ena_i,
   input  logic [4:0]  reg_w_addr_i,
   input  logic [31:0] reg_w_data_i,
   input  logic        ram_r_ena_i,
   input  logic [31:0] ram_r_addr_i,
   input  logic        ram_w_ena_i,
   input  logic [31:0] ram_w_addr_i,
   input  logic [31:0] ram_w_data_i,
   output logic        dram_req_o,
   output logic        dram_we_o,
   output logic [31:0] dram_addr_o,
   output logic [31:0] dram_wdata_o,
   output logic [3:0]  dram_wstrb_o,
   input  logic [31:0] dram_rdata_i,
   input  logic        dram_ack_i,
   output logic        stall_o,
   output logic        reg_w_ena_o,
   output logic [4:0]  reg_w_addr_o,
   output logic [31:0] reg_w_data_o
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic        misalign_o
`endif
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state, state_nxt;
   logic        mem_op, start;
   logic [2:0]  f3;
   logic [31:0] req_addr;
   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic        lat_we, lat_rd_ena;
   logic [4:0]  lat_rd_addr;
   logic [31:0] lat_addr, lat_wdata;
   logic [3:0]  lat_wstrb;
   logic [2:0]  lat_f3;
   logic [1:0]  lat_off;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic        unused_inst_bits;

   assign f3       = inst_i[14:12];
   assign mem_op   = ram_r_ena_i | ram_w_ena_i;
   // A simultaneous load and store resolves to the load.
   assign req_addr = ram_r_ena_i ? ram_r_addr_i : ram_w_addr_i;
   assign unused_inst_bits = ^{inst_i[31:15], inst_i[11:0]};

`ifdef MEM_MISALIGN_TRAP_EN
   logic misaligned;
   // Classify the access width and flag addresses that are not naturally aligned.
   always_comb begin
      misaligned = 1'b0;
      if (ram_r_ena_i) begin
         if (f3[1:0] == 2'b01)  misaligned = req_addr[0];
         else if (f3[1])        misaligned = (req_addr[1:0] != 2'b00);
      end else begin
         if (f3 == 3'b001)      misaligned = req_addr[0];
         else if (f3 != 3'b000) misaligned = (req_addr[1:0] != 2'b00);
      end
   end
   assign start = mem_op & ~misaligned;
`else
   assign start = mem_op;
`endif

   // Replicate store data across lanes and build the byte strobes.
   always_comb begin
      st_wdata = ram_w_data_i;
      st_wstrb = 4'b1111;
      case (f3)
         3'b000: begin
            st_wdata = {4{ram_w_data_i[7:0]}};
            st_wstrb = 4'b0001 << req_addr[1:0];
         end
         3'b001: begin
            st_wdata = {2{ram_w_data_i[15:0]}};
            st_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   // Capture the request fields when an access is launched from IDLE.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         lat_we      <= 1'b0;
         lat_addr    <= 32'h0;
         lat_wdata   <= 32'h0;
         lat_wstrb   <= 4'h0;
         lat_f3      <= 3'h0;
         lat_off     <= 2'h0;
         lat_rd_ena  <= 1'b0;
         lat_rd_addr <= 5'h0;
      end else if (state == IDLE && start) begin
         lat_we      <= ~ram_r_ena_i;
         lat_addr    <= {req_addr[31:2], 2'b00};
         lat_wdata   <= ram_r_ena_i ? 32'h0 : st_wdata;
         lat_wstrb   <= ram_r_ena_i ? 4'h0  : st_wstrb;
         lat_f3      <= f3;
         lat_off     <= req_addr[1:0];
         lat_rd_ena  <= reg_w_ena_i;
         lat_rd_addr <= reg_w_addr_i;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next state, RAM port drive and stall.
   always_comb begin
      state_nxt    = state;
      dram_req_o   = 1'b0;
      dram_we_o    = 1'b0;
      dram_addr_o  = 32'h0;
      dram_wdata_o = 32'h0;
      dram_wstrb_o = 4'h0;
      stall_o      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = BUSY;
               stall_o   = 1'b1;
            end
         end
         BUSY: begin
            dram_req_o   = 1'b1;
            dram_we_o    = lat_we;
            dram_addr_o  = lat_addr;
            dram_wdata_o = lat_wdata;
            dram_wstrb_o = lat_wstrb;
            if (dram_ack_i) state_nxt = IDLE;
            else            stall_o   = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Select the addressed lane of the returned word and extend it.
   always_comb begin
      case (lat_off)
         2'd0:    ld_byte = dram_rdata_i[7:0];
         2'd1:    ld_byte = dram_rdata_i[15:8];
         2'd2:    ld_byte = dram_rdata_i[23:16];
         default: ld_byte = dram_rdata_i[31:24];
      endcase
      ld_half = lat_off[1] ? dram_rdata_i[31:16] : dram_rdata_i[15:0];
      case (lat_f3)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'h0, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'h0, ld_half};
         default: ld_data = dram_rdata_i;
      endcase
   end

   // Write-back register towards the wb stage.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         reg_w_ena_o  <= 1'b0;
         reg_w_addr_o <= 5'h0;
         reg_w_data_o <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_o   <= 1'b0;
`endif
      end else begin
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_o <= 1'b0;
`endif
         if (state == IDLE) begin
            if (!mem_op) begin
               reg_w_ena_o  <= reg_w_ena_i;
               reg_w_addr_o <= reg_w_addr_i;
               reg_w_data_o <= reg_w_data_i;
            end else begin
               reg_w_ena_o <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
               if (misaligned) misalign_o <= 1'b1;
`endif
            end
         end else if (dram_ack_i) begin
            if (!lat_we) begin
               reg_w_ena_o  <= lat_rd_ena;
               reg_w_addr_o <= lat_rd_addr;
               reg_w_data_o <= ld_data;
            end else begin
               reg_w_ena_o <= 1'b0;
            end
         end
      end
   end

endmodule
